// File: rtl/arm_emit_sequencer.sv
// arm_emit_sequencer
//   Serializes translated ARM instruction bundles (up to SLOTS words each)
//   into the instruction memory write port, one word per accepted memory
//   cycle. Owns the write pointer, honours mem_ready backpressure and stops
//   permanently (FULL) once the word at DEPTH-1 has been written.
//
//   Optional build macro: EMIT_TRACE_EN
//     When defined, every retired word is logged as a 32-char binary data
//     field, a space, then the decimal address.
//     Simulation only; cycle behaviour is identical with or without it.
module arm_emit_sequencer #(
  parameter int SLOTS      = 6,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    bundle_valid,
  output logic                    bundle_ready,
  input  logic [32*SLOTS-1:0]     instructions,
  input  logic [3:0]              quantity,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_ready,
  output logic                    busy,
  output logic [ADDR_WIDTH:0]     emitted_count,
  output logic                    overflow,
  output logic                    qty_err
);

  // Slot index needs to hold 0..SLOTS-1; one spare bit keeps SLOTS=1 legal.
  localparam int                    IW        = $clog2(SLOTS + 1);
  localparam logic [3:0]            SLOTS_Q   = 4'(SLOTS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, EMIT, FULL} state_t;

  state_t                  state;
  logic [SLOTS-1:0][31:0]  slot_buf;
  logic [IW-1:0]           idx;
  logic [IW-1:0]           last_idx;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [3:0]              q_cap;
  logic [IW-1:0]           idx_nxt;

  // Clamp the requested word count to what the buffer can hold.
  always_comb begin
    q_cap   = (quantity > SLOTS_Q) ? SLOTS_Q : quantity;
    idx_nxt = idx + IW'(1);
  end

  // Handshake / status outputs are pure decodes of the registered state.
  assign bundle_ready = (state == IDLE);
  assign busy         = (state == EMIT);
  assign mem_addr     = ptr;

  // Sequencer FSM: accept a bundle in IDLE, stream its words in EMIT,
  // latch up in FULL once the last memory location has been written.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      slot_buf      <= '0;
      idx           <= '0;
      last_idx      <= '0;
      ptr           <= '0;
      emitted_count <= '0;
      overflow      <= 1'b0;
      qty_err       <= 1'b0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bundle_valid) begin
            slot_buf <= instructions;
            idx      <= '0;
            last_idx <= IW'(q_cap - 4'd1);
            if (quantity > SLOTS_Q) qty_err <= 1'b1;
            // Empty bundles are consumed in place without touching memory.
            if (q_cap != 4'd0) begin
              state     <= EMIT;
              mem_we    <= 1'b1;
              mem_wdata <= instructions[31:0];
            end
          end
        end
        EMIT: begin
          // mem_we is held high throughout EMIT, so mem_ready alone retires.
          if (mem_ready) begin
            emitted_count <= emitted_count + 1'b1;
            if (ptr == LAST_ADDR) begin
              // Memory exhausted: drop whatever is left and stop for good.
              overflow <= 1'b1;
              state    <= FULL;
              mem_we   <= 1'b0;
            end else begin
              ptr <= ptr + 1'b1;
              if (idx == last_idx) begin
                state  <= IDLE;
                mem_we <= 1'b0;
              end else begin
                idx       <= idx_nxt;
                mem_wdata <= slot_buf[idx_nxt];
              end
            end
          end
        end
        FULL: begin
          mem_we <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

`ifdef EMIT_TRACE_EN
  // Log each retired word: binary data, then decimal address.
  always @(posedge clk) begin
    if (reset_n && mem_we && mem_ready)
      $display("%b %0d", mem_wdata, mem_addr);
  end
`else
`endif

endmodule

// File: tb/tb_arm_emit_sequencer.sv
// Directed bench for arm_emit_sequencer with a write scoreboard.
module tb_arm_emit_sequencer;
  localparam int SLOTS = 6;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  bundle_valid = 1'b0;
  logic                  bundle_ready;
  logic [32*SLOTS-1:0]   instructions = '0;
  logic [3:0]            quantity = '0;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ready = 1'b1;
  logic                  busy;
  logic [AW:0]           emitted_count;
  logic                  overflow;
  logic                  qty_err;

  arm_emit_sequencer #(.SLOTS(SLOTS), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bundle_valid(bundle_valid),
    .bundle_ready(bundle_ready), .instructions(instructions),
    .quantity(quantity), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy),
    .emitted_count(emitted_count), .overflow(overflow), .qty_err(qty_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic [31:0] d; } exp_t;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ptr = 0;
  bit   exp_full = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Retire monitor: a write seen here is committed at the next posedge.
  always @(negedge clk) begin
    if (reset_n && mem_we && mem_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%0d data=%h expected none", mem_addr, mem_wdata);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.a));
        chk("wr_data", 64'(mem_wdata), 64'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    sb.delete();
    exp_ptr  = 0;
    exp_full = 0;
  endtask

  // Push the expected writes, then offer the bundle until it is accepted.
  // Returns one ns after the accepting edge.
  task automatic send(input logic [SLOTS-1:0][31:0] w, input int q);
    int qq, n;
    qq = (q > SLOTS) ? SLOTS : q;
    for (int k = 0; k < qq; k++) begin
      if (!exp_full) begin
        sb.push_back('{AW'(exp_ptr), w[k]});
        if (exp_ptr == DEPTH - 1) exp_full = 1;
        else exp_ptr++;
      end
    end
    instructions = w;
    quantity     = 4'(q);
    bundle_valid = 1'b1;
    n = 0;
    while (!bundle_ready && n < 50) begin tick(); n++; end
    if (!bundle_ready) chk("send_timeout", 64'(bundle_ready), 64'd1);
    tick();
    bundle_valid = 1'b0;
    instructions = '0;
    quantity     = '0;
  endtask

  // Wait for the scoreboard to empty, then let the last retire land.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin tick(); n++; end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    tick();
  endtask

  initial begin
    logic [SLOTS-1:0][31:0] w;

    // Reset state
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_ready", 64'(bundle_ready), 64'd1);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(emitted_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_qerr", 64'(qty_err), 64'd0);

    // iconst_1 bundle, mem_ready tied high
    w = '0; w[0] = 32'hE3A01001; w[1] = 32'hE92D0002;
    send(w, 2);
    chk("ic_we0", 64'(mem_we), 64'd1);
    chk("ic_addr0", 64'(mem_addr), 64'd0);
    chk("ic_data0", 64'(mem_wdata), 64'hE3A01001);
    chk("ic_busy", 64'(busy), 64'd1);
    chk("ic_rdy0", 64'(bundle_ready), 64'd0);
    tick();
    chk("ic_addr1", 64'(mem_addr), 64'd1);
    chk("ic_data1", 64'(mem_wdata), 64'hE92D0002);
    chk("ic_rdy1", 64'(bundle_ready), 64'd0);
    tick();
    chk("ic_rdy2", 64'(bundle_ready), 64'd1);
    chk("ic_we2", 64'(mem_we), 64'd0);
    chk("ic_count", 64'(emitted_count), 64'd2);
    chk("ic_sb", 64'(sb.size()), 64'd0);

    // Backpressure on word 1 of a 3-word bundle
    do_reset();
    w = '0; w[0] = 32'h11110000; w[1] = 32'h22221111; w[2] = 32'h33332222;
    send(w, 3);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_we", 64'(mem_we), 64'd1);
      chk("bp_addr", 64'(mem_addr), 64'd1);
      chk("bp_data", 64'(mem_wdata), 64'h22221111);
    end
    mem_ready = 1'b1;
    drain();
    chk("bp_count", 64'(emitted_count), 64'd3);
    chk("bp_idle", 64'(bundle_ready), 64'd1);

    // Empty bundle, then oversize bundle
    w = '0;
    send(w, 0);
    chk("q0_ready", 64'(bundle_ready), 64'd1);
    chk("q0_we", 64'(mem_we), 64'd0);
    chk("q0_qerr", 64'(qty_err), 64'd0);
    tick();
    chk("q0_we1", 64'(mem_we), 64'd0);
    for (int k = 0; k < SLOTS; k++) w[k] = 32'hA0000000 + 32'(k);
    send(w, 9);
    drain();
    chk("q9_count", 64'(emitted_count), 64'd9);
    chk("q9_qerr", 64'(qty_err), 64'd1);
    chk("q9_addr", 64'(mem_addr), 64'd9);

    // Overflow: preload to 1022, then a 4-word bundle
    do_reset();
    for (int b = 0; b < 170; b++) begin
      for (int k = 0; k < SLOTS; k++) w[k] = $urandom;
      send(w, 6);
    end
    for (int k = 0; k < SLOTS; k++) w[k] = $urandom;
    send(w, 2);
    drain();
    chk("pre_addr", 64'(mem_addr), 64'd1022);
    chk("pre_count", 64'(emitted_count), 64'd1022);
    chk("pre_ovf", 64'(overflow), 64'd0);
    w = '0; w[0] = 32'hDEAD0000; w[1] = 32'hDEAD0001; w[2] = 32'hDEAD0002; w[3] = 32'hDEAD0003;
    send(w, 4);
    drain();
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_ready", 64'(bundle_ready), 64'd0);
    chk("ovf_busy", 64'(busy), 64'd0);
    chk("ovf_count", 64'(emitted_count), 64'd1024);
    bundle_valid = 1'b1; quantity = 4'd1; instructions = '1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("full_we", 64'(mem_we), 64'd0);
      chk("full_ready", 64'(bundle_ready), 64'd0);
    end
    bundle_valid = 1'b0;

    // Reset during word 2 of a 5-word bundle
    do_reset();
    for (int k = 0; k < SLOTS; k++) w[k] = 32'hC0DE0000 + 32'(k);
    send(w, 5);
    tick(); tick();
    chk("mr_addr2", 64'(mem_addr), 64'd2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mr_we", 64'(mem_we), 64'd0);
    chk("mr_addr", 64'(mem_addr), 64'd0);
    chk("mr_count", 64'(emitted_count), 64'd0);
    chk("mr_ready", 64'(bundle_ready), 64'd1);
    chk("mr_left", 64'(sb.size()), 64'd3);
    sb.delete(); exp_ptr = 0; exp_full = 0;
    w = '0; w[0] = 32'h0BADF00D;
    send(w, 1);
    drain();
    chk("mr_count1", 64'(emitted_count), 64'd1);
    chk("mr_addr1", 64'(mem_addr), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
